breakout_level_controller: RTL and testbench

Top-level game-flow controller for the breakout core. It owns port A of the block-state RAM, which it shares between its own level-fill sequencer and the physics engine. It sequences physics resets and frame-update starts, and tracks remaining blocks, lives and level number. It sits between the frame timing generator, the physics engine and the block-state RAM.

---
 rtl/breakout_level_controller_pkg.sv | 24 ++
 rtl/breakout_level_controller.sv | 154 +++++++++++++++
 tb/tb_breakout_level_controller.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/breakout_level_controller_pkg.sv
// Shared breakout game definitions: block-field geometry, life count and
// the level-controller state encoding, used by physics, renderer and flow control.
package breakout_level_controller_pkg;

  localparam int GAME_BLOCK_COUNT = 72;
  localparam int GAME_START_LIVES = 3;
  localparam int ADDR_W           = 7;

  // The entry just past the last real block is a permanently-empty slot.
  function automatic logic [ADDR_W-1:0] dummy_addr(input int block_count);
    return ADDR_W'(block_count);
  endfunction

  localparam logic [ADDR_W-1:0] GAME_DUMMY_ADDR = dummy_addr(GAME_BLOCK_COUNT);

  typedef enum logic [2:0] {
    ST_FILL      = 3'd0,
    ST_ARM       = 3'd1,
    ST_PLAY      = 3'd2,
    ST_RESPAWN   = 3'd3,
    ST_GAME_OVER = 3'd4
  } state_e;

endpackage

// File: rtl/breakout_level_controller.sv
// Game-flow controller: owns block-RAM port A (level fill vs. physics),
// sequences physics resets/frame starts and tracks blocks, lives and level.
module breakout_level_controller
  import breakout_level_controller_pkg::*;
#(
  parameter int BLOCK_COUNT = GAME_BLOCK_COUNT,
  parameter int START_LIVES = GAME_START_LIVES
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              FRAME_TICK,
  input  logic              BTN_RELEASE,
  input  logic              BALL_LOST,
  input  logic              BLOCK_CLEARED,
  input  logic [ADDR_W-1:0] PHYS_ADDR,
  input  logic              PHYS_WE,
  input  logic              PHYS_WDATA,
  output logic [ADDR_W-1:0] MEM_ADDR,
  output logic              MEM_WE,
  output logic              MEM_WDATA,
  output logic              PHYS_RESET,
  output logic              PHYS_START_UPDATE,
  output logic [2:0]        LIVES,
  output logic [3:0]        LEVEL,
  output logic              GAME_OVER
);

  localparam logic [ADDR_W-1:0] DUMMY_ADDR  = dummy_addr(BLOCK_COUNT);
  localparam logic [ADDR_W-1:0] FULL_COUNT  = ADDR_W'(BLOCK_COUNT);
  localparam logic [2:0]        LIVES_INIT  = 3'(START_LIVES);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] fill_q, fill_d;
  logic [ADDR_W-1:0] remaining_q, remaining_d;
  logic [2:0]        lives_q, lives_d;
  logic [3:0]        level_q, level_d;
  logic              ball_prev_q, ball_prev_d;
  logic              btn_prev_q;
  logic              phys_reset_q;
  logic              game_over_q;

  logic ball_rise;
  logic btn_rise;
  logic in_play;

  assign in_play   = (state_q == ST_PLAY);
  assign ball_rise = BALL_LOST & ~ball_prev_q;
  assign btn_rise  = BTN_RELEASE & ~btn_prev_q;

  always_comb begin
    state_d     = state_q;
    fill_d      = fill_q;
    remaining_d = remaining_q;
    lives_d     = lives_q;
    level_d     = level_q;
    // Holding the previous value at 1 outside PLAY masks a BALL_LOST that is
    // still high when physics comes out of reset.
    ball_prev_d = 1'b1;

    case (state_q)
      ST_FILL: begin
        fill_d = fill_q + 1'b1;
        if (fill_q == DUMMY_ADDR) begin
          state_d     = ST_ARM;
          fill_d      = '0;
          remaining_d = FULL_COUNT;
        end
      end
      ST_ARM: state_d = ST_PLAY;
      ST_PLAY: begin
        ball_prev_d = BALL_LOST;
        if (BLOCK_CLEARED && (remaining_q != '0))
          remaining_d = remaining_q - 1'b1;
        // Clearing the last block takes priority over a coincident ball loss.
        if (remaining_d == '0) begin
          level_d = level_q + 4'd1;
          state_d = ST_FILL;
          fill_d  = '0;
        end else if (ball_rise) begin
          if (lives_q > 3'd1) begin
            lives_d = lives_q - 3'd1;
            state_d = ST_RESPAWN;
          end else begin
            lives_d = 3'd0;
            state_d = ST_GAME_OVER;
          end
        end
      end
      ST_RESPAWN: state_d = ST_PLAY;
      ST_GAME_OVER: begin
        if (btn_rise) begin
          lives_d = LIVES_INIT;
          level_d = 4'd0;
          fill_d  = '0;
          state_d = ST_FILL;
        end
      end
      default: begin
        state_d = ST_FILL;
        fill_d  = '0;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q      <= ST_FILL;
      fill_q       <= '0;
      remaining_q  <= FULL_COUNT;
      lives_q      <= LIVES_INIT;
      level_q      <= 4'd0;
      ball_prev_q  <= 1'b1;
      btn_prev_q   <= 1'b1;
      phys_reset_q <= 1'b1;
      game_over_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      fill_q       <= fill_d;
      remaining_q  <= remaining_d;
      lives_q      <= lives_d;
      level_q      <= level_d;
      ball_prev_q  <= ball_prev_d;
      btn_prev_q   <= BTN_RELEASE;
      phys_reset_q <= (state_d != ST_PLAY);
      game_over_q  <= (state_d == ST_GAME_OVER);
    end
  end

  // Port A: physics passes straight through in PLAY so its read latency is
  // untouched; the fill writes come from the state/counter registers.
  always_comb begin
    MEM_ADDR  = '0;
    MEM_WE    = 1'b0;
    MEM_WDATA = 1'b0;
    if (!RESET) begin
      if (in_play) begin
        MEM_ADDR  = PHYS_ADDR;
        MEM_WE    = PHYS_WE;
        MEM_WDATA = PHYS_WDATA;
      end else if (state_q == ST_FILL) begin
        MEM_ADDR  = fill_q;
        MEM_WE    = 1'b1;
        MEM_WDATA = (fill_q != DUMMY_ADDR);
      end
    end
  end

  assign PHYS_START_UPDATE = in_play & FRAME_TICK;
  assign PHYS_RESET        = phys_reset_q;
  assign LIVES             = lives_q;
  assign LEVEL             = level_q;
  assign GAME_OVER         = game_over_q;

endmodule

// File: tb/tb_breakout_level_controller.sv
// Directed bench for breakout_level_controller: fill writes scored against a
// queue of expected (address, data) pairs, flow/counter behaviour checked inline.
module tb_breakout_level_controller;

  logic       CLK = 1'b0;
  logic       RESET = 1'b1;
  logic       FRAME_TICK = 1'b0;
  logic       BTN_RELEASE = 1'b0;
  logic       BALL_LOST = 1'b0;
  logic       BLOCK_CLEARED = 1'b0;
  logic [6:0] PHYS_ADDR = '0;
  logic       PHYS_WE = 1'b0;
  logic       PHYS_WDATA = 1'b0;
  logic [6:0] MEM_ADDR;
  logic       MEM_WE;
  logic       MEM_WDATA;
  logic       PHYS_RESET;
  logic       PHYS_START_UPDATE;
  logic [2:0] LIVES;
  logic [3:0] LEVEL;
  logic       GAME_OVER;

  int checks = 0;
  int errors = 0;
  int sb_q[$];

  breakout_level_controller dut (
    .CLK               (CLK),
    .RESET             (RESET),
    .FRAME_TICK        (FRAME_TICK),
    .BTN_RELEASE       (BTN_RELEASE),
    .BALL_LOST         (BALL_LOST),
    .BLOCK_CLEARED     (BLOCK_CLEARED),
    .PHYS_ADDR         (PHYS_ADDR),
    .PHYS_WE           (PHYS_WE),
    .PHYS_WDATA        (PHYS_WDATA),
    .MEM_ADDR          (MEM_ADDR),
    .MEM_WE            (MEM_WE),
    .MEM_WDATA         (MEM_WDATA),
    .PHYS_RESET        (PHYS_RESET),
    .PHYS_START_UPDATE (PHYS_START_UPDATE),
    .LIVES             (LIVES),
    .LEVEL             (LEVEL),
    .GAME_OVER         (GAME_OVER)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #2;
  endtask

  // Called in the first FILL cycle; runs until the first PLAY cycle.
  task automatic run_fill(input string tag);
    int writes;
    int play_at;
    logic [31:0] got;
    writes  = 0;
    play_at = -1;
    sb_q.delete();
    for (int a = 0; a <= 72; a++) sb_q.push_back(a * 2 + ((a < 72) ? 1 : 0));
    for (int cyc = 0; cyc < 120; cyc++) begin
      FRAME_TICK = (cyc < 70) && (cyc % 3 == 0);
      #1;
      if (MEM_WE === 1'b1) begin
        writes++;
        got = {24'd0, MEM_ADDR, MEM_WDATA};
        if (sb_q.size() == 0) chk({tag, " extra write"}, writes, 73);
        else chk({tag, " write addr/data"}, got, sb_q.pop_front());
      end
      chk({tag, " phys_reset"}, PHYS_RESET, (cyc < 74) ? 1 : 0);
      chk({tag, " start_update masked"}, PHYS_START_UPDATE, 0);
      if (PHYS_RESET === 1'b0) begin
        play_at = cyc;
        break;
      end
      tick();
    end
    FRAME_TICK = 1'b0;
    chk({tag, " write count"}, writes, 73);
    chk({tag, " first play cycle"}, play_at, 74);
  endtask

  initial begin
    // Reset state
    RESET = 1'b1;
    FRAME_TICK = 1'b1;
    tick();
    tick();
    chk("rst mem_we", MEM_WE, 0);
    chk("rst mem_addr", MEM_ADDR, 0);
    chk("rst mem_wdata", MEM_WDATA, 0);
    chk("rst phys_reset", PHYS_RESET, 1);
    chk("rst start_update", PHYS_START_UPDATE, 0);
    chk("rst game_over", GAME_OVER, 0);
    chk("rst lives", LIVES, 3);
    chk("rst level", LEVEL, 0);
    FRAME_TICK = 1'b0;
    RESET = 1'b0;
    run_fill("fill0");
    chk("play lives", LIVES, 3);
    chk("play level", LEVEL, 0);

    // Port mux and frame start pass-through
    PHYS_ADDR = 7'd5; PHYS_WE = 1'b1; PHYS_WDATA = 1'b0; FRAME_TICK = 1'b1;
    #1;
    chk("mux addr", MEM_ADDR, 5);
    chk("mux we", MEM_WE, 1);
    chk("mux wdata", MEM_WDATA, 0);
    chk("start_update", PHYS_START_UPDATE, 1);
    PHYS_ADDR = 7'd99; PHYS_WDATA = 1'b1;
    #1;
    chk("mux addr2", MEM_ADDR, 99);
    chk("mux wdata2", MEM_WDATA, 1);
    PHYS_ADDR = '0; PHYS_WE = 1'b0; PHYS_WDATA = 1'b0; FRAME_TICK = 1'b0;
    tick();

    // Level clear: last block coincides with a ball-lost rise
    for (int i = 0; i < 72; i++) begin
      BLOCK_CLEARED = 1'b1;
      if (i == 71) begin
        BALL_LOST = 1'b1;
        chk("pre-clear still play", PHYS_RESET, 0);
        chk("pre-clear level", LEVEL, 0);
      end
      tick();
    end
    BLOCK_CLEARED = 1'b0;
    chk("clear level", LEVEL, 1);
    chk("clear lives kept", LIVES, 3);
    chk("clear phys_reset", PHYS_RESET, 1);
    run_fill("refill");
    repeat (3) tick();
    chk("held ball_lost no loss", LIVES, 3);
    chk("held ball_lost level", LEVEL, 1);
    BALL_LOST = 1'b0;
    tick();

    // First ball loss, held high through respawn
    BALL_LOST = 1'b1;
    tick();
    PHYS_WE = 1'b1;
    #1;
    chk("loss1 lives", LIVES, 2);
    chk("respawn phys_reset", PHYS_RESET, 1);
    chk("respawn we ignored", MEM_WE, 0);
    tick();
    PHYS_WE = 1'b0;
    chk("respawn one cycle", PHYS_RESET, 0);
    repeat (3) tick();
    chk("loss1 no repeat", LIVES, 2);
    BALL_LOST = 1'b0;
    tick();

    // Second and third losses lead to game over
    BALL_LOST = 1'b1;
    tick();
    chk("loss2 lives", LIVES, 1);
    tick();
    BALL_LOST = 1'b0;
    tick();
    BALL_LOST = 1'b1;
    tick();
    BALL_LOST = 1'b0;
    chk("loss3 lives", LIVES, 0);
    chk("game_over", GAME_OVER, 1);
    chk("game_over phys_reset", PHYS_RESET, 1);
    FRAME_TICK = 1'b1;
    #1;
    chk("game_over start masked", PHYS_START_UPDATE, 0);
    FRAME_TICK = 1'b0;
    repeat (2) tick();
    chk("game_over holds", GAME_OVER, 1);
    BTN_RELEASE = 1'b1;
    tick();
    BTN_RELEASE = 1'b0;
    chk("restart lives", LIVES, 3);
    chk("restart level", LEVEL, 0);
    chk("restart game_over", GAME_OVER, 0);
    chk("restart phys_reset", PHYS_RESET, 1);

    // Reset in the middle of the fill restarts at address 0
    repeat (40) tick();
    chk("midfill addr", MEM_ADDR, 40);
    chk("midfill we", MEM_WE, 1);
    RESET = 1'b1;
    tick();
    chk("midfill rst we", MEM_WE, 0);
    RESET = 1'b0;
    run_fill("fill after reset");
    chk("final lives", LIVES, 3);
    chk("final level", LEVEL, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
